// File: rtl/drv7seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
//
// Contents:
//   SEG_A / SEG_G / SEG_DP  bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
//   glyph_t                 7-bit active-high glyph {g,f,e,d,c,b,a}
//   SEG_TABLE               hex glyphs 0-9, A, b, C, d, E, F (active high)
//   blink_phase_e           blink phase, used only when DRV7SEG_BLINK_EN is defined
package drv7seg_pkg;

    localparam int unsigned SEG_A   = 0;
    localparam int unsigned SEG_G   = 6;
    localparam int unsigned SEG_DP  = 7;
    localparam int unsigned GLYPH_W = 7;

    typedef logic [GLYPH_W-1:0] glyph_t;

    // Index is the nibble value; bit 0 is segment a.
    localparam glyph_t SEG_TABLE [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    typedef enum logic {
        PhaseOff = 1'b0,
        PhaseOn  = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/drv7seg_dec.sv
// Nibble to 7-segment glyph decoder, active-high, purely combinational.
//
// Ports:
//   nib_i  hex value 0..F
//   seg_o  glyph {g,f,e,d,c,b,a}, 1 = segment lit
module drv7seg_dec
    import drv7seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output glyph_t     seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/drv7seg_scan.sv
// Time-multiplexed 7-segment display driver.
//
// Scans NDIG digits, SCAN_DIV clocks per digit slot. The first cycle of every slot is a
// dead cycle with all commons off; brightness is a PWM window inside the slot. Display data
// is captured into shadow registers once per frame so a frame never shows mixed data.
// Outputs are registered and lag the internal scan counters by one cycle.
//
// Build option: define DRV7SEG_BLINK_EN to add I_BLINK, parameter BLINK_FRAMES and the
// per-digit blink logic. Without it the block has no blink port and no frame counter.
//
// Ports:
//   I_CLK      clock
//   I_RESET    asynchronous active-high reset
//   I_DIGITS   4*NDIG bits, nibble k = hex value of digit k (digit 0 at the LSBs)
//   I_DOTS     decimal point per digit, 1 = lit
//   I_DRVEN    digit enable, 0 = blank
//   I_BRIGHT   brightness level, lit window scales with I_BRIGHT+1
//   I_LZB      leading-zero blanking enable
//   I_BLINK    per-digit blink select (DRV7SEG_BLINK_EN only)
//   O_COM      digit commons, polarity per COM_ACT_LOW
//   O_DRV7SEG  segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   O_FRAME    one-cycle pulse after the last cycle of a full scan
module drv7seg_scan
    import drv7seg_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 1953,
    parameter int BRIGHT_W    = 3,
    parameter int COM_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
`ifdef DRV7SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic [4*NDIG-1:0]   I_DIGITS,
    input  logic [NDIG-1:0]     I_DOTS,
    input  logic [NDIG-1:0]     I_DRVEN,
    input  logic [BRIGHT_W-1:0] I_BRIGHT,
    input  logic                I_LZB,
`ifdef DRV7SEG_BLINK_EN
    input  logic [NDIG-1:0]     I_BLINK,
`endif
    output logic [NDIG-1:0]     O_COM,
    output logic [7:0]          O_DRV7SEG,
    output logic                O_FRAME
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DIG_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Wide enough for SCAN_DIV * 2^BRIGHT_W without overflow.
    localparam int CMP_W  = SLOT_W + BRIGHT_W + 1;

    localparam logic [NDIG-1:0] COM_OFF = (COM_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
    localparam logic [7:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    // Scan counters
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic                slot_wrap;
    logic                frame_end;

    // Shadow copies of the display inputs, refreshed once per frame
    logic [4*NDIG-1:0]   sh_digits_q, sh_digits_d;
    logic [NDIG-1:0]     sh_dots_q, sh_dots_d;
    logic [NDIG-1:0]     sh_drven_q, sh_drven_d;
    logic [BRIGHT_W-1:0] sh_bright_q, sh_bright_d;
    logic                sh_lzb_q, sh_lzb_d;

    // Registered outputs
    logic [NDIG-1:0]     com_q, com_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_q, frame_d;

    // Per-digit selection for the digit currently being scanned
    logic [NDIG-1:0]     upper_zero;
    logic [3:0]          cur_nib;
    logic                cur_dot;
    logic                cur_en;
    logic                cur_upper_zero;
    logic                cur_blink_off;
    glyph_t              cur_glyph;

    logic [CMP_W-1:0]    lit_lhs;
    logic [CMP_W-1:0]    lit_rhs;
    logic                lit;
    logic                blank;
    logic                dot_on;
    logic [NDIG-1:0]     com_ah;
    logic [7:0]          seg_ah;

    // ------------------------------------------------------------------
    // Scan counters and frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
        frame_end  = slot_wrap && (dig_q == DIG_W'(NDIG - 1));

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;

        dig_d = dig_q;
        if (slot_wrap) begin
            dig_d = (dig_q == DIG_W'(NDIG - 1)) ? '0 : dig_q + 1'b1;
        end

        sh_digits_d = sh_digits_q;
        sh_dots_d   = sh_dots_q;
        sh_drven_d  = sh_drven_q;
        sh_bright_d = sh_bright_q;
        sh_lzb_d    = sh_lzb_q;
        if (frame_end) begin
            sh_digits_d = I_DIGITS;
            sh_dots_d   = I_DOTS;
            sh_drven_d  = I_DRVEN;
            sh_bright_d = I_BRIGHT;
            sh_lzb_d    = I_LZB;
        end
    end

    // ------------------------------------------------------------------
    // Blink phase (optional)
    // ------------------------------------------------------------------
`ifdef DRV7SEG_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NDIG-1:0] sh_blink_q, sh_blink_d;
    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_e    phase_q, phase_d;

    always_comb begin
        sh_blink_d  = frame_end ? I_BLINK : sh_blink_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            sh_blink_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= PhaseOn;
        end else begin
            sh_blink_q  <= sh_blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Current digit data
    // ------------------------------------------------------------------
    // upper_zero[k]: nibbles k..NDIG-1 of the shadow data are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NDIG-1] = (sh_digits_q[4*(NDIG-1) +: 4] == 4'h0);
        for (int k = NDIG - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (sh_digits_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib        = '0;
        cur_dot        = 1'b0;
        cur_en         = 1'b0;
        cur_upper_zero = 1'b0;
        cur_blink_off  = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_q == DIG_W'(k)) begin
                cur_nib        = sh_digits_q[4*k +: 4];
                cur_dot        = sh_dots_q[k];
                cur_en         = sh_drven_q[k];
                cur_upper_zero = upper_zero[k];
`ifdef DRV7SEG_BLINK_EN
                cur_blink_off  = sh_blink_q[k] && (phase_q == PhaseOff);
`endif
            end
        end
    end

    drv7seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_glyph)
    );

    // ------------------------------------------------------------------
    // Output stage: PWM window, blanking, polarity
    // ------------------------------------------------------------------
    always_comb begin
        // Lit while slot_cnt * 2^BRIGHT_W < SCAN_DIV * (bright + 1), never on slot_cnt 0.
        lit_lhs = CMP_W'({slot_cnt_q, {BRIGHT_W{1'b0}}});
        lit_rhs = CMP_W'(SCAN_DIV) * (CMP_W'(sh_bright_q) + CMP_W'(1));
        lit     = (slot_cnt_q != '0) && (lit_lhs < lit_rhs);

        blank  = !cur_en || (sh_lzb_q && (dig_q != '0) && cur_upper_zero) || cur_blink_off;
        // A leading-zero-blanked digit may still show its dot; a disabled or blinked-off
        // digit may not.
        dot_on = cur_dot && cur_en && !cur_blink_off;

        seg_ah              = '0;
        seg_ah[SEG_DP]      = dot_on;
        seg_ah[SEG_G:SEG_A] = blank ? '0 : cur_glyph;

        com_ah = '0;
        for (int k = 0; k < NDIG; k++) begin
            com_ah[k] = (dig_q == DIG_W'(k));
        end

        if (!lit) begin
            com_ah = '0;
            seg_ah = '0;
        end

        com_d   = (COM_ACT_LOW != 0) ? ~com_ah : com_ah;
        seg_d   = (SEG_ACT_LOW != 0) ? ~seg_ah : seg_ah;
        frame_d = frame_end;
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            slot_cnt_q  <= '0;
            dig_q       <= '0;
            sh_digits_q <= '0;
            sh_dots_q   <= '0;
            sh_drven_q  <= '0;
            sh_bright_q <= '0;
            sh_lzb_q    <= 1'b0;
            com_q       <= COM_OFF;
            seg_q       <= SEG_OFF;
            frame_q     <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            dig_q       <= dig_d;
            sh_digits_q <= sh_digits_d;
            sh_dots_q   <= sh_dots_d;
            sh_drven_q  <= sh_drven_d;
            sh_bright_q <= sh_bright_d;
            sh_lzb_q    <= sh_lzb_d;
            com_q       <= com_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
        end
    end

    assign O_COM     = com_q;
    assign O_DRV7SEG = seg_q;
    assign O_FRAME   = frame_q;

endmodule
